// File: rtl/wishbone_ram_target.sv
// Wishbone B4 pipelined-mode RAM target: lane-masked writes, fixed-latency ACK/ERR,
// outstanding-request limit via STALL, out-of-range words terminate with ERR.
module wishbone_ram_target #(
  parameter int unsigned AddressWidth   = 16,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned Granularity    = 8,
  parameter int unsigned Depth          = 256,
  parameter int unsigned Latency        = 2,
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          LOWPOWER       = 1'b1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             CYC,
  input  logic                             STB,
  input  logic                             WE,
  input  logic [AddressWidth-1:0]          ADDR,
  input  logic [DataWidth/Granularity-1:0] SEL,
  input  logic [DataWidth-1:0]             DAT_ToTarget,
  output logic [DataWidth-1:0]             DAT_ToInitiator,
  output logic                             ACK,
  output logic                             ERR,
  output logic                             RTY,
  output logic                             STALL
);

  localparam int unsigned SelWidth = DataWidth / Granularity;
  localparam int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned Last     = Latency - 1;
  localparam logic [AddressWidth:0] DepthExt = (AddressWidth + 1)'(Depth);

  logic [DataWidth-1:0] mem [Depth];

  logic [Latency-1:0]   vld_q;
  logic [Latency-1:0]   err_q;
  logic [DataWidth-1:0] dat_q [Latency];

  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 accept;
  logic                 in_range;
  logic                 term_vld;
  logic [IdxWidth-1:0]  idx;
  logic [DataWidth-1:0] rd_data;

  assign in_range = ({1'b0, ADDR} < DepthExt);
  assign idx      = ADDR[IdxWidth-1:0];

  // Dropping CYC kills the termination that would otherwise show this cycle.
  assign term_vld = vld_q[Last] & CYC;
  assign STALL    = CYC & (cnt_q == CntWidth'(MaxOutstanding)) & ~term_vld;
  assign accept   = CYC & STB & ~STALL;

  assign ACK = term_vld & ~err_q[Last];
  assign ERR = term_vld & err_q[Last];
  assign RTY = 1'b0;

  always_comb begin
    DAT_ToInitiator = dat_q[Last];
    if (LOWPOWER && !ACK) begin
      DAT_ToInitiator = '0;
    end
  end

  // Reads see every write accepted on an earlier edge, giving in-order read-after-write.
  always_comb begin
    rd_data = '0;
    if (!WE && in_range) begin
      rd_data = mem[idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (accept && WE && in_range) begin
      for (int i = 0; i < SelWidth; i++) begin
        if (SEL[i]) begin
          mem[idx][i*Granularity +: Granularity] <= DAT_ToTarget[i*Granularity +: Granularity];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < Latency; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      err_q[0] <= accept & ~in_range;
      dat_q[0] <= rd_data;
      for (int i = 1; i < Latency; i++) begin
        vld_q[i] <= vld_q[i-1] & CYC;
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!CYC) begin
      cnt_d = '0;
    end else if (accept && !term_vld) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (!accept && term_vld) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wishbone_ram_target.sv
// Scoreboard bench for wishbone_ram_target: a default instance (Latency 2) and a
// backpressure instance (Latency 3, one outstanding) share stimulus, selected by tgt.
module tb_wishbone_ram_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [15:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdat;
  int          tgt;

  logic        cyc_a, cyc_b;
  logic        a_ack, a_err, a_rty, a_stall;
  logic        b_ack, b_err, b_rty, b_stall;
  logic [31:0] a_rdat, b_rdat;

  always #5 clk = ~clk;

  assign cyc_a = cyc && (tgt == 0);
  assign cyc_b = cyc && (tgt == 1);

  wishbone_ram_target dut_a (
    .CLK             (clk),
    .RST             (rst_n),
    .CYC             (cyc_a),
    .STB             (stb),
    .WE              (we),
    .ADDR            (addr),
    .SEL             (sel),
    .DAT_ToTarget    (wdat),
    .DAT_ToInitiator (a_rdat),
    .ACK             (a_ack),
    .ERR             (a_err),
    .RTY             (a_rty),
    .STALL           (a_stall)
  );

  wishbone_ram_target #(
    .Latency        (3),
    .MaxOutstanding (1)
  ) dut_b (
    .CLK             (clk),
    .RST             (rst_n),
    .CYC             (cyc_b),
    .STB             (stb),
    .WE              (we),
    .ADDR            (addr),
    .SEL             (sel),
    .DAT_ToTarget    (wdat),
    .DAT_ToInitiator (b_rdat),
    .ACK             (b_ack),
    .ERR             (b_err),
    .RTY             (b_rty),
    .STALL           (b_stall)
  );

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][256];
  int          errors = 0;
  int          checks = 0;
  int          cnt    = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, target %0d)",
               tag, act, exp, cnt, tgt);
    end
  endtask

  // One bus cycle: check outputs at negedge, record an accept, then cross the posedge.
  task automatic step(output bit acc, output bit stl);
    logic        ack, err, rty, stall;
    logic [31:0] dat;
    exp_t        e;
    @(negedge clk);
    ack   = (tgt == 1) ? b_ack   : a_ack;
    err   = (tgt == 1) ? b_err   : a_err;
    rty   = (tgt == 1) ? b_rty   : a_rty;
    stall = (tgt == 1) ? b_stall : a_stall;
    dat   = (tgt == 1) ? b_rdat  : a_rdat;
    acc   = 1'b0;
    stl   = stall;
    check_val("ack_err_excl", 64'(ack & err), 64'd0);
    check_val("rty", 64'(rty), 64'd0);
    if (!cyc) check_val("stall_idle", 64'(stall), 64'd0);
    if (ack || err) begin
      if (sb.size() == 0) begin
        check_val("unexpected_term", 64'({ack, err}), 64'd0);
      end else begin
        e = sb.pop_front();
        check_val("term_cycle", 64'(cnt), 64'(e.cyc));
        check_val("err", 64'(err), 64'(e.err));
        check_val("ack", 64'(ack), 64'(!e.err));
        if (e.chk) check_val("rdata", 64'(dat), 64'(e.dat));
      end
    end else begin
      if (sb.size() > 0 && sb[0].cyc <= cnt) begin
        e = sb.pop_front();
        check_val("term_missing", 64'({ack, err}), 64'({!e.err, e.err}));
      end
      check_val("idle_dat", 64'(dat), 64'd0);
    end
    if (rst_n && cyc && stb && !stall) begin
      acc   = 1'b1;
      e.err = (addr >= 16'd256);
      e.chk = !we;
      e.dat = '0;
      e.cyc = cnt + ((tgt == 1) ? 3 : 2);
      if (!e.err) begin
        if (we) begin
          for (int i = 0; i < 4; i++) begin
            if (sel[i]) model[tgt][addr[7:0]][i*8 +: 8] = wdat[i*8 +: 8];
          end
        end else begin
          e.dat = model[tgt][addr[7:0]];
        end
      end
      sb.push_back(e);
    end
    @(posedge clk);
    cnt++;
    #1;
  endtask

  task automatic idle(input int n);
    bit acc, stl;
    for (int i = 0; i < n; i++) step(acc, stl);
  endtask

  // Leaves STB high so a following issue() continues back-to-back.
  task automatic issue(input bit w, input logic [15:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    bit acc, stl;
    int n;
    n    = 0;
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = w;
    addr = a;
    sel  = s;
    wdat = d;
    do begin
      step(acc, stl);
      n++;
    end while (!acc && n < 20);
    if (!acc) check_val("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    bit acc, stl;
    int n;
    n   = 0;
    stb = 1'b0;
    while (sb.size() > 0 && n < 20) begin
      step(acc, stl);
      n++;
    end
    check_val("drain", 64'(sb.size()), 64'd0);
    idle(2);
  endtask

  initial begin
    int  idx, stalls, cycles;
    bit  acc, stl;
    rst_n = 1'b0;
    cyc   = 1'b0;
    stb   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    sel   = '0;
    wdat  = '0;
    tgt   = 0;

    idle(3);
    rst_n = 1'b1;
    idle(10);

    // Full write then read-back; byte-lane merge.
    issue(1'b1, 16'd5, 4'b1111, 32'hDEADBEEF);
    issue(1'b0, 16'd5, 4'b1111, 32'h0);
    drain();
    issue(1'b1, 16'd5, 4'b0100, 32'h00AA0000);
    issue(1'b0, 16'd5, 4'b1111, 32'h0);
    drain();

    // Back-to-back stream, SEL=0 no-op write, boundary addresses.
    for (int i = 0; i < 4; i++) issue(1'b1, 16'(10 + i), 4'b1111, 32'h1000_0000 * (i + 1) + i);
    for (int i = 0; i < 4; i++) issue(1'b0, 16'(10 + i), 4'b1111, 32'h0);
    issue(1'b1, 16'd10, 4'b0000, 32'hFFFFFFFF);
    issue(1'b0, 16'd10, 4'b1111, 32'h0);
    issue(1'b1, 16'd0, 4'b1111, 32'hA5A5_0000);
    issue(1'b1, 16'd255, 4'b0011, 32'h0000_5A5A);
    issue(1'b0, 16'd0, 4'b1111, 32'h0);
    drain();

    // Out of range must not alias onto a low address.
    issue(1'b1, 16'd44, 4'b1111, 32'h12345678);
    issue(1'b1, 16'd300, 4'b1111, 32'hFFFFFFFF);
    issue(1'b0, 16'd300, 4'b1111, 32'h0);
    issue(1'b0, 16'd256, 4'b1111, 32'h0);
    issue(1'b0, 16'd44, 4'b1111, 32'h0);
    issue(1'b0, 16'd255, 4'b1111, 32'h0);
    drain();

    // Abort: in-flight reads dropped with CYC, then a fresh cycle.
    issue(1'b1, 16'd1, 4'b1111, 32'h1111_1111);
    issue(1'b1, 16'd2, 4'b1111, 32'h2222_2222);
    issue(1'b1, 16'd7, 4'b1111, 32'h7777_7777);
    drain();
    issue(1'b0, 16'd1, 4'b1111, 32'h0);
    issue(1'b0, 16'd2, 4'b1111, 32'h0);
    cyc = 1'b0;
    stb = 1'b0;
    sb.delete();
    idle(5);
    issue(1'b0, 16'd7, 4'b1111, 32'h0);
    drain();

    // Reset mid-pipeline: nothing may terminate afterwards.
    issue(1'b0, 16'd5, 4'b1111, 32'h0);
    issue(1'b0, 16'd7, 4'b1111, 32'h0);
    stb   = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    idle(2);
    rst_n = 1'b1;
    idle(6);
    issue(1'b0, 16'd7, 4'b1111, 32'h0);
    drain();
    cyc = 1'b0;
    idle(2);

    // Backpressure on the Latency 3 / one-outstanding instance.
    tgt = 1;
    issue(1'b1, 16'd1, 4'b1111, 32'hB1B1_0001);
    issue(1'b1, 16'd2, 4'b1111, 32'hB2B2_0002);
    issue(1'b1, 16'd3, 4'b1111, 32'hB3B3_0003);
    drain();
    idx    = 0;
    stalls = 0;
    cycles = 0;
    cyc    = 1'b1;
    stb    = 1'b1;
    we     = 1'b0;
    sel    = 4'b1111;
    while (idx < 3 && cycles < 30) begin
      addr = 16'(idx + 1);
      step(acc, stl);
      cycles++;
      if (stl) stalls++;
      if (acc) idx++;
    end
    check_val("bp_accepts", 64'(idx), 64'd3);
    check_val("bp_stalls", 64'(stalls), 64'd4);
    drain();
    cyc = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wishbone_ram_target.md
Name: wishbone_ram_target

Overview:
- Wishbone B4 pipelined-mode target: word-addressed on-chip RAM that terminates the requests an initiator or skid-buffer stage issues.
- Byte-lane writes via SEL; fixed read/ack latency; outstanding-request limit enforced with STALL.
- Out-of-range accesses terminate with ERR.
- Serves as the bus endpoint and the reference target for bus-stage testbenches.

Parameters:
AddressWidth, 16, word address width of ADDR
DataWidth, 32, data bus width in bits (8/16/32/64)
Granularity, 8, bits per SEL lane
Depth, 256, number of RAM words; valid addresses 0..Depth-1
Latency, 2, cycles from accept edge to ACK/ERR (1..4)
MaxOutstanding, 2, max accepted-but-unterminated requests (1..Latency)
LOWPOWER, 1, drive DAT_ToInitiator to 0 when ACK is low

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
CYC  in  1  bus cycle
STB  in  1  strobe
WE  in  1  write enable
ADDR  in  AddressWidth  word address
SEL  in  DataWidth/Granularity  lane select
DAT_ToTarget  in  DataWidth  write data
DAT_ToInitiator  out  DataWidth  read data, valid with ACK
ACK  out  1  normal termination
ERR  out  1  error termination
RTY  out  1  tied 0
STALL  out  1  request not accepted this cycle

Behaviour:
- Reset (RST=0, async): ACK=ERR=0, STALL=0, DAT_ToInitiator=0, outstanding count=0, pipeline valid bits cleared. RAM contents are not reset.
- Accept: accept = CYC & STB & !STALL at a rising CLK edge.
- Write accept: RAM[ADDR] lanes with SEL[i]=1 updated at that edge. SEL=0 is a no-op write, still ACKed.
- Read accept: RAM[ADDR] sampled at that edge, using post-write state of earlier-accepted writes. This gives in-order read-after-write.
- Range check: ADDR >= Depth -> no RAM access; ERR, not ACK, at termination; DAT_ToInitiator=0.
- Response pipeline: shift register of Latency stages, each holding {valid, err, data}. ACK (or ERR) is a registered output, high exactly one cycle, Latency cycles after accept. Terminations occur in accept order; back-to-back accepts give back-to-back ACKs.
- Outstanding count n:
  - n increments on accept, decrements on termination; both in one cycle leave n unchanged.
  - STALL = CYC & (n == MaxOutstanding) & !(termination this cycle).
  - Combinational, so a slot freed by a same-cycle termination is reusable immediately.
  - With MaxOutstanding == Latency, STALL never asserts.
- CYC low: all in-flight stages flushed at the next edge. No ACK/ERR is emitted for them, n returns to 0, and STALL=0. Writes already accepted remain committed.
- CYC low is also evaluated mid-pipeline: if CYC drops in the cycle a termination would occur, that ACK/ERR is suppressed.
- STB without CYC is ignored.
- ACK and ERR are never simultaneously high; RTY is constant 0.
- LOWPOWER=1: DAT_ToInitiator = ACK ? stage data : 0. LOWPOWER=0: DAT_ToInitiator shows the final stage data unconditionally.
- Reset asserted mid-operation clears the pipeline immediately, with no stray ACK after release.

Test Plan:
- Reset then idle: RST=0 for 3 cycles, release -> ACK=ERR=STALL=0 and DAT_ToInitiator=0 for 10 idle cycles.
- Write 0xDEADBEEF to addr 5 with SEL=4'b1111, then read addr 5 -> ACK 2 cycles after each accept; read data 0xDEADBEEF.
- Byte-lane write 0x00AA0000 to addr 5 with SEL=4'b0100, then read addr 5 -> 0xDEAABEEF.
- Out of range: read addr 300 with Depth=256 -> ERR 2 cycles later, ACK=0, DAT_ToInitiator=0, RAM unchanged.
- Backpressure: Latency=3, MaxOutstanding=1, STB held for reads of addresses 1,2,3 -> STALL high 2 of every 3 cycles; 3 ACKs total, in order, with data RAM[1], RAM[2], RAM[3].
- Abort: accept reads of addr 1 and 2, drop CYC the next cycle -> no ACK/ERR follows. A fresh cycle then reading addr 7 gets exactly one ACK, Latency cycles after accept.
